dmem_responder: RTL and testbench

Data-memory responder serving the load/store requests that the pipelined core's MEM stage issues. It accepts one word-wide read or write at a time and models a configurable number of wait states. While an access is in flight it drives a stall request back to the pipeline, then completes with a one-cycle acknowledge. It replaces the zero-latency data memory so the core's stall path is exercised against a realistic slave.

---
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-wide data-memory slave with WAIT_CYCLES wait states, a stall request and a one-cycle ack.
// Optional misaligned-access checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        ack,
  output logic        err
);

  // state   | meaning
  // ST_IDLE | waiting for a request; busy follows the request inputs
  // ST_WAIT | access captured, counting down wait states, busy=1
  // ST_DONE | memory access done on entry; ack=1, busy=0

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nxt;
  logic [AW-1:0]  r_idx;
  logic [31:0]    r_wdata;
  logic           r_is_wr;
  logic           r_mis;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic           w_req;
  logic           w_accept;
  logic           w_mis_in;
  logic           w_commit;
  logic [AW-1:0]  w_acc_idx;
  logic [31:0]    w_acc_wdata;
  logic           w_acc_wr;
  logic           w_acc_mis;

`ifdef DMEM_ALIGN_CHECK_EN
  logic w_unused_addr;
  assign w_unused_addr = ^addr[31:AW+2];
  assign w_mis_in      = (addr[1:0] != 2'b00);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign w_mis_in      = 1'b0;
`endif

  assign w_req    = mem_read | mem_write;
  assign w_accept = (r_state == ST_IDLE) && w_req;

  // With zero wait states DONE is entered straight from IDLE, before the
  // capture registers are loaded, so the access uses the live inputs then.
  assign w_acc_idx   = (r_state == ST_IDLE) ? addr[AW+1:2] : r_idx;
  assign w_acc_wdata = (r_state == ST_IDLE) ? wdata        : r_wdata;
  assign w_acc_wr    = (r_state == ST_IDLE) ? mem_write    : r_is_wr;
  assign w_acc_mis   = (r_state == ST_IDLE) ? w_mis_in     : r_mis;

  assign w_commit = !reset && (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          busy        = 1'b1;
          w_cnt_nxt   = LP_WAIT;
          w_state_nxt = (LP_WAIT == 4'd0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy      = 1'b1;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_is_wr <= 1'b0;
      r_mis   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= addr[AW+1:2];
        r_wdata <= wdata;
        r_is_wr <= mem_write;
        r_mis   <= w_mis_in;
      end
      if (w_commit && !w_acc_wr) begin
        rdata <= w_acc_mis ? 32'd0 : r_mem[w_acc_idx];
      end
    end
  end

  // Storage has no reset; contents survive reset and power up undefined.
  always_ff @(posedge clk) begin
    if (w_commit && w_acc_wr && !w_acc_mis) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  assign ack = (r_state == ST_DONE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign err = ack & r_mis;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 3 wait states) checked against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WC [3] = '{2, 0, 3};
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst  [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] ad   [3];
  logic [31:0] wd   [3];
  logic [31:0] rdat [3];
  logic        bsy  [3];
  logic        ak   [3];
  logic        er   [3];

  logic [31:0] mdl [3][DEPTH];
  bit          mval [3][DEPTH];
  logic [31:0] exp_rd [3];
  bit          exp_known [3];

  int nerr = 0;
  int nchk = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .rdata(rdat[0]), .busy(bsy[0]), .ack(ak[0]), .err(er[0]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .rdata(rdat[1]), .busy(bsy[1]), .ack(ak[1]), .err(er[1]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst[2]), .mem_read(rd[2]), .mem_write(wr[2]), .addr(ad[2]),
    .wdata(wd[2]), .rdata(rdat[2]), .busy(bsy[2]), .ack(ak[2]), .err(er[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One access from request to ack; leaves the request asserted in the ack cycle.
  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int  wt;
    bit  mis;
    int  idx;
    wt  = WC[i];
    mis = ALIGN_EN && (a % 4 != 0);
    idx = int'((a / 4) % DEPTH);
    @(negedge clk);
    rd[i] = r; wr[i] = w; ad[i] = a; wd[i] = d;
    for (int c = 0; c <= wt + 1; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == wt + 1) begin
        if (w) begin
          if (!mis) begin
            mdl[i][idx]  = d;
            mval[i][idx] = 1'b1;
          end
        end else if (mis) begin
          exp_rd[i]    = 32'd0;
          exp_known[i] = 1'b1;
        end else begin
          exp_rd[i]    = mdl[i][idx];
          exp_known[i] = mval[i][idx];
        end
      end
      nchk++;
      if (bsy[i] !== (c <= wt)) begin
        nerr++;
        $display("FAIL %s busy inst%0d cyc%0d got %b want %b", tag, i, c, bsy[i], (c <= wt));
      end
      nchk++;
      if (ak[i] !== (c == wt + 1)) begin
        nerr++;
        $display("FAIL %s ack inst%0d cyc%0d got %b want %b", tag, i, c, ak[i], (c == wt + 1));
      end
      nchk++;
      if (er[i] !== (c == wt + 1 && mis)) begin
        nerr++;
        $display("FAIL %s err inst%0d cyc%0d got %b want %b", tag, i, c, er[i], (c == wt + 1 && mis));
      end
      if (exp_known[i]) begin
        nchk++;
        if (rdat[i] !== exp_rd[i]) begin
          nerr++;
          $display("FAIL %s rdata inst%0d cyc%0d got %h want %h", tag, i, c, rdat[i], exp_rd[i]);
        end
      end
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    rd[i] = 1'b0; wr[i] = 1'b0;
    #1;
    nchk++;
    if (bsy[i] !== 1'b0 || ak[i] !== 1'b0 || er[i] !== 1'b0) begin
      nerr++;
      $display("FAIL idle inst%0d got busy=%b ack=%b err=%b want 0 0 0", i, bsy[i], ak[i], er[i]);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = 32'd0; wd[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (rdat[i] !== 32'd0 || ak[i] !== 1'b0 || er[i] !== 1'b0 || bsy[i] !== 1'b0) begin
        nerr++;
        $display("FAIL reset_vals inst%0d got rdata=%h ack=%b err=%b busy=%b want 0", i, rdat[i], ak[i], er[i], bsy[i]);
      end
      rd[i] = 1'b1;
      #1;
      nchk++;
      if (bsy[i] !== 1'b1) begin
        nerr++;
        $display("FAIL reset_busy_follows inst%0d got %b want 1", i, bsy[i]);
      end
      rd[i] = 1'b0;
      exp_rd[i] = 32'd0;
      exp_known[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
  endtask

  task automatic test_basic_w2;
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, "w2_write");
    idle(0);
    access(0, 1, 0, 32'h10, 32'h0, "w2_read");
    idle(0);
  endtask

  task automatic test_zero_wait;
    for (int k = 0; k < 3; k++) begin
      access(1, 0, 1, 32'h4, 32'h12345678 + k, "w0_write");
      access(1, 1, 0, 32'h4, 32'h0, "w0_read");
    end
    idle(1);
  endtask

  task automatic test_alias;
    access(0, 0, 1, 32'h000, 32'hA5A5A5A5, "alias_write");
    access(0, 1, 0, 32'h400, 32'h0, "alias_read");
    idle(0);
  endtask

  task automatic test_both;
    access(0, 1, 1, 32'h20, 32'h55, "both_as_write");
    idle(0);
    access(0, 1, 0, 32'h20, 32'h0, "both_read_back");
    idle(0);
  endtask

  task automatic test_reset_mid;
    access(2, 0, 1, 32'h30, 32'h11111111, "rst_pre_write");
    idle(2);
    @(negedge clk);
    wr[2] = 1'b1; rd[2] = 1'b0; ad[2] = 32'h30; wd[2] = 32'h22222222;
    #1;
    nchk++;
    if (bsy[2] !== 1'b1) begin
      nerr++;
      $display("FAIL rst_wait_c0 busy got %b want 1", bsy[2]);
    end
    @(negedge clk);
    rst[2] = 1'b1; wr[2] = 1'b0;
    #1;
    nchk++;
    if (bsy[2] !== 1'b1 || ak[2] !== 1'b0) begin
      nerr++;
      $display("FAIL rst_wait_c1 got busy=%b ack=%b want 1 0", bsy[2], ak[2]);
    end
    @(negedge clk);
    rst[2] = 1'b0;
    #1;
    nchk++;
    if (bsy[2] !== 1'b0 || rdat[2] !== 32'd0) begin
      nerr++;
      $display("FAIL rst_wait_after got busy=%b rdata=%h want 0 0", bsy[2], rdat[2]);
    end
    for (int c = 0; c < 5; c++) begin
      nchk++;
      if (ak[2] !== 1'b0) begin
        nerr++;
        $display("FAIL rst_wait_no_ack cyc%0d got %b want 0", c, ak[2]);
      end
      @(negedge clk);
      #1;
    end
    exp_rd[2] = 32'd0;
    exp_known[2] = 1'b1;
    access(2, 1, 0, 32'h30, 32'h0, "rst_old_value");
    idle(2);
    access(2, 0, 1, 32'h30, 32'h33333333, "rst_done_write");
    rst[2] = 1'b1; wr[2] = 1'b0;
    @(negedge clk);
    #1;
    nchk++;
    if (ak[2] !== 1'b0 || rdat[2] !== 32'd0) begin
      nerr++;
      $display("FAIL rst_done got ack=%b rdata=%h want 0 0", ak[2], rdat[2]);
    end
    rst[2] = 1'b0;
    exp_rd[2] = 32'd0;
    idle(2);
    access(2, 1, 0, 32'h30, 32'h0, "rst_done_kept");
    idle(2);
  endtask

  task automatic test_align;
    access(0, 0, 1, 32'h30, 32'hCAFEF00D, "align_base");
    idle(0);
    access(0, 0, 1, 32'h32, 32'h0BADBEEF, "align_miswrite");
    idle(0);
    access(0, 1, 0, 32'h30, 32'h0, "align_readback");
    idle(0);
    access(0, 1, 0, 32'h31, 32'h0, "align_misread");
    idle(0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 40; n++) begin
        int unsigned op;
        logic [31:0] a;
        op = $urandom_range(0, 3);
        a  = 32'($urandom_range(0, 31)) << 2;
        a  = a | (32'($urandom_range(0, 3)) << 10);
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        case (op)
          0, 3:    access(i, 1, 0, a, $urandom, "rand_read");
          1:       access(i, 0, 1, a, $urandom, "rand_write");
          default: access(i, 1, 1, a, $urandom, "rand_both");
        endcase
        if ($urandom_range(0, 2) == 0) idle(i);
      end
      idle(i);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      exp_rd[i] = 32'd0;
      exp_known[i] = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mdl[i][k]  = 32'd0;
        mval[i][k] = 1'b0;
      end
    end
    test_reset;
    test_basic_w2;
    test_zero_wait;
    test_alias;
    test_both;
    test_reset_mid;
    test_align;
    test_random;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
